updown_step_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared WIDTH-bit up/down step counter. Up to NREQ requesters each ask for a single up or down step. The block grants one requester at a time, applies its step to the counter, and returns a one-cycle grant. It sits between the control-path requesters and the shared count value, and owns the counter register, the wrap/saturate policy and the boundary flag.

---
 rtl/updown_step_arbiter.sv | 136 +++++++++++++
 tb/tb_updown_step_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_step_arbiter.sv
// Round-robin arbiter and sequencer for a shared up/down step counter.
// Each granted requester applies one +1/-1 step to the counter, with a
// per-cycle choice of modulo wrap or saturation at the boundaries.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous, active-high reset
//   req      - per-requester step request (level, held until granted)
//   dir      - per-requester direction, 1 = up, 0 = down
//   wrap_en  - 1 = wrap at boundaries, 0 = saturate
//   clear    - synchronous clear of count, highest priority
//   gnt      - one-hot grant pulse, one cycle wide
//   count    - current counter value
//   lim      - boundary flag, pulses with gnt
//   busy     - high during the grant (HOLD) cycle
module updown_step_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  dir,
  input  logic             wrap_en,
  input  logic             clear,
  output logic [NREQ-1:0]  gnt,
  output logic [WIDTH-1:0] count,
  output logic             lim,
  output logic             busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    ptr, ptr_nx;
  logic [WIDTH-1:0] count_nx;
  logic [NREQ-1:0]  gnt_nx;
  logic             lim_nx;
  logic             busy_nx;

  logic             found_c;
  logic [PW-1:0]    win_c;
  logic [WIDTH-1:0] stepped_c;
  logic             at_lim_c;

  // Round-robin search: first requester at or above ptr, wrapping modulo NREQ.
  always_comb begin
    int unsigned idx;
    found_c = 1'b0;
    win_c   = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found_c && req[idx]) begin
        found_c = 1'b1;
        win_c   = PW'(idx);
      end
    end
  end

  // Winner's step; a blocked (saturated) step leaves count unchanged but flags lim.
  always_comb begin
    stepped_c = count;
    at_lim_c  = 1'b0;
    if (dir[win_c]) begin
      if (count == {WIDTH{1'b1}}) begin
        at_lim_c  = 1'b1;
        stepped_c = wrap_en ? '0 : count;
      end else begin
        stepped_c = count + WIDTH'(1);
      end
    end else begin
      if (count == '0) begin
        at_lim_c  = 1'b1;
        stepped_c = wrap_en ? {WIDTH{1'b1}} : count;
      end else begin
        stepped_c = count - WIDTH'(1);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    count_nx = count;
    gnt_nx   = '0;
    lim_nx   = 1'b0;
    busy_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (clear) begin
          count_nx = '0;
        end else if (found_c) begin
          gnt_nx   = NREQ'(1) << win_c;
          count_nx = stepped_c;
          lim_nx   = at_lim_c;
          busy_nx  = 1'b1;
          ptr_nx   = (win_c == PW'(NREQ - 1)) ? '0 : win_c + PW'(1);
          state_nx = HOLD;
        end
      end
      HOLD: begin
        // A clear here discards the step granted on the previous edge.
        if (clear) count_nx = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      count <= '0;
      gnt   <= '0;
      lim   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      count <= count_nx;
      gnt   <= gnt_nx;
      lim   <= lim_nx;
      busy  <= busy_nx;
    end
  end

endmodule

// File: tb/tb_updown_step_arbiter.sv
// Self-checking bench for updown_step_arbiter (NREQ=4, WIDTH=3).
// A cycle model pushes the expected {busy,lim,count,gnt} before each edge;
// the sample taken after the edge is popped and compared.
module tb_updown_step_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] dir;
  logic       wrap_en;
  logic       clear;
  logic [3:0] gnt;
  logic [2:0] count;
  logic       lim;
  logic       busy;

  int total;
  int bad;

  logic [8:0] sb_q[$];

  // reference model state
  bit m_hold;
  int m_ptr;
  int m_count;
  int m_gnt;
  bit m_lim;
  bit m_busy;

  updown_step_arbiter #(.NREQ(4), .WIDTH(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .dir     (dir),
    .wrap_en (wrap_en),
    .clear   (clear),
    .gnt     (gnt),
    .count   (count),
    .lim     (lim),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_hold = 0; m_ptr = 0; m_count = 0; m_gnt = 0; m_lim = 0; m_busy = 0;
  endtask

  // Behavioural next-cycle model from the current inputs.
  task automatic m_step();
    int w;
    if (m_hold) begin
      m_hold = 0; m_gnt = 0; m_lim = 0; m_busy = 0;
      if (clear) m_count = 0;
    end else if (clear) begin
      m_count = 0; m_gnt = 0; m_lim = 0; m_busy = 0;
    end else if (req != 4'b0000) begin
      w = -1;
      for (int i = 0; i < 4; i++) begin
        if (w < 0 && req[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
      end
      m_gnt  = 1 << w;
      m_ptr  = (w + 1) % 4;
      m_busy = 1;
      m_hold = 1;
      m_lim  = 0;
      if (dir[w]) begin
        if (m_count == 7) begin m_lim = 1; if (wrap_en) m_count = 0; end
        else m_count = m_count + 1;
      end else begin
        if (m_count == 0) begin m_lim = 1; if (wrap_en) m_count = 7; end
        else m_count = m_count - 1;
      end
    end else begin
      m_gnt = 0; m_lim = 0; m_busy = 0;
    end
  endtask

  // One clock: push the model's expectation, then compare the DUT after the edge.
  task automatic cyc(input string tag);
    logic [8:0] e;
    m_step();
    e = {m_busy, m_lim, 3'(m_count), 4'(m_gnt)};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag, 32'({busy, lim, count, gnt}), 32'(sb_q.pop_front()));
  endtask

  // A grant cycle with independent constant expectations on top of the model.
  task automatic grant(input string tag, input logic [3:0] eg, input logic [2:0] ec, input logic el);
    cyc(tag);
    check({tag, "_gnt"}, 32'(gnt), 32'(eg));
    check({tag, "_cnt"}, 32'(count), 32'(ec));
    check({tag, "_lim"}, 32'(lim), 32'(el));
  endtask

  task automatic hold_cyc(input string tag);
    cyc(tag);
    check({tag, "_gnt0"}, 32'(gnt), 32'd0);
    check({tag, "_busy0"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; dir = '0; clear = 1'b0; wrap_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_reset();
    reset = 1'b1; req = '0; dir = '0; wrap_en = 1'b1; clear = 1'b0;

    // reset and idle
    do_reset();
    check("rst_vals", 32'({busy, lim, count, gnt}), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc("idle");
      check("idle_cnt", 32'(count), 32'd0);
    end

    // single requester counting up with wrap
    req = 4'b0001; dir = 4'b0001; wrap_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      grant("up", 4'b0001, 3'(k % 8), (k == 8));
      if (k == 8) req = 4'b0000;
      hold_cyc("up_hold");
    end

    // saturation at both ends
    do_reset();
    wrap_en = 1'b0; req = 4'b0010; dir = 4'b0000;
    grant("sat_dn", 4'b0010, 3'd0, 1'b1);
    req = 4'b0000;
    hold_cyc("sat_dn_hold");
    wrap_en = 1'b1; req = 4'b0010; dir = 4'b0000;
    grant("wrap_dn", 4'b0010, 3'd7, 1'b1);
    req = 4'b0000;
    hold_cyc("wrap_dn_hold");
    wrap_en = 1'b0; req = 4'b0010; dir = 4'b0010;
    grant("sat_up", 4'b0010, 3'd7, 1'b1);
    req = 4'b0000;
    hold_cyc("sat_up_hold");

    // round-robin fairness
    do_reset();
    wrap_en = 1'b1; req = 4'b1111; dir = 4'b1111;
    grant("rr0", 4'b0001, 3'd1, 1'b0); hold_cyc("rr_h");
    grant("rr1", 4'b0010, 3'd2, 1'b0); hold_cyc("rr_h");
    grant("rr2", 4'b0100, 3'd3, 1'b0); hold_cyc("rr_h");
    grant("rr3", 4'b1000, 3'd4, 1'b0); hold_cyc("rr_h");
    grant("rr4", 4'b0001, 3'd5, 1'b0);
    req = 4'b0000;
    hold_cyc("rr_h");

    // mixed directions, arranged so the pointer sits at 0 with count 3
    do_reset();
    req = 4'b1000; dir = 4'b1000;
    for (int k = 1; k <= 3; k++) begin
      grant("pre", 4'b1000, 3'(k), 1'b0);
      hold_cyc("pre_h");
    end
    req = 4'b0101; dir = 4'b0001;
    grant("mix0", 4'b0001, 3'd4, 1'b0);
    req = 4'b0100;
    hold_cyc("mix_h");
    grant("mix1", 4'b0100, 3'd3, 1'b0);
    req = 4'b0000;
    hold_cyc("mix_h");

    // clear while idle, then served on the next edge
    req = 4'b0010; dir = 4'b0010; clear = 1'b1;
    cyc("clr_idle");
    check("clr_idle_gnt", 32'(gnt), 32'd0);
    check("clr_idle_cnt", 32'(count), 32'd0);
    clear = 1'b0;
    grant("clr_served", 4'b0010, 3'd1, 1'b0);
    // clear during hold discards the step
    req = 4'b0000; clear = 1'b1;
    hold_cyc("clr_hold");
    check("clr_hold_cnt", 32'(count), 32'd0);
    clear = 1'b0;
    cyc("post_clr");

    // random traffic against the model
    for (int i = 0; i < 300; i++) begin
      req     = 4'($urandom_range(0, 15));
      dir     = 4'($urandom_range(0, 15));
      wrap_en = 1'($urandom_range(0, 1));
      clear   = ($urandom_range(0, 9) == 0);
      cyc("rand");
    end
    clear = 1'b0;

    // asynchronous reset in the middle of a grant
    do_reset();
    req = 4'b0100; dir = 4'b0100;
    grant("pre_rst", 4'b0100, 3'd1, 1'b0);
    reset = 1'b1;
    #1;
    check("async_rst", 32'({busy, lim, count, gnt}), 32'd0);
    req = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    cyc("after_rst");
    cyc("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
